// File: rtl/seg_pkg.sv
// Shared constants and types for the binary-to-seven-segment display block.
package seg_pkg;

  localparam int unsigned SEG_W     = 8;
  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [SEG_W-1:0] SEG_BLANK   = 8'hff;
  localparam logic [SEG_W-1:0] SEG_DASH    = 8'hbf;
  localparam logic [SEG_W-1:0] SEG_DP_MASK = 8'h7f;

  // Active-low {dp,g,f,e,d,c,b,a}; index n holds the pattern for digit n.
  localparam logic [9:0][SEG_W-1:0] SEG_CODES = {
    8'h90, 8'h80, 8'hf8, 8'h82, 8'h92, 8'h99, 8'hb0, 8'ha4, 8'hf9, 8'hc0
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ENCODE = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// One BCD digit to an active-low segment pattern, with blanking and decimal point.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0]       digit_i,
  input  logic             blank_i,
  input  logic             dp_i,
  output logic [SEG_W-1:0] seg_c_o
);

  logic [SEG_W-1:0] base;

  always_comb begin
    base = SEG_BLANK;
    if (!blank_i && (digit_i <= 4'd9)) begin
      base = SEG_CODES[digit_i];
    end
    seg_c_o = dp_i ? (base & SEG_DP_MASK) : base;
  end

endmodule

// File: rtl/seg_bin_display.sv
// Sequential double-dabble conversion of a binary count into six registered
// segment patterns with leading-zero blanking, decimal points and overflow dashes.
module seg_bin_display
  import seg_pkg::*;
#(
  parameter int unsigned BIN_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] bin_data,
  input  logic [5:0]       dp_en,
  output logic             done,
  output logic             overflow,
  output logic [7:0]       seg_data_0,
  output logic [7:0]       seg_data_1,
  output logic [7:0]       seg_data_2,
  output logic [7:0]       seg_data_3,
  output logic [7:0]       seg_data_4,
  output logic [7:0]       seg_data_5
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned BCD_W = 4 * NUM_DIGITS;

  seg_state_e                        state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [BCD_W-1:0]                  bcd_q, bcd_d;
  logic [BIN_W-1:0]                  bin_q, bin_d;
  logic [5:0]                        dp_q, dp_d;
  logic                              ovf_q, ovf_d;
  logic                              in_ready_q, in_ready_d;
  logic                              done_q, done_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]  seg_q, seg_d;

  logic [BCD_W-1:0]                  bcd_adj;
  logic [NUM_DIGITS-1:0]             blank;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]  dec_seg;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]  seg_enc;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // A digit blanks only if it and every higher digit are zero; units never blank.
  always_comb begin
    blank = '0;
    blank[5] = (bcd_q[23:20] == 4'd0);
    for (int i = 4; i >= 1; i--) begin
      blank[i] = blank[i+1] && (bcd_q[4*i +: 4] == 4'd0);
    end
    blank[0] = 1'b0;
  end

  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_dec
    seg_hex_decode u_dec (
      .digit_i (bcd_q[4*g +: 4]),
      .blank_i (blank[g]),
      .dp_i    (dp_q[g]),
      .seg_c_o (dec_seg[g])
    );

    assign seg_enc[g] = ovf_q ? (dp_q[g] ? (SEG_DASH & SEG_DP_MASK) : SEG_DASH)
                              : dec_seg[g];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    dp_d       = dp_q;
    ovf_d      = ovf_q;
    in_ready_d = in_ready_q;
    done_d     = 1'b0;
    seg_d      = seg_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = SHIFT;
          bin_d      = bin_data;
          dp_d       = dp_en;
          ovf_d      = (32'(bin_data) > 32'd999999);
          bcd_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        seg_d      = seg_enc;
        done_d     = 1'b1;
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bcd_q      <= '0;
      bin_q      <= '0;
      dp_q       <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      seg_q      <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      dp_q       <= dp_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      seg_q      <= seg_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign seg_data_0 = seg_q[0];
  assign seg_data_1 = seg_q[1];
  assign seg_data_2 = seg_q[2];
  assign seg_data_3 = seg_q[3];
  assign seg_data_4 = seg_q[4];
  assign seg_data_5 = seg_q[5];

endmodule

// File: tb/tb_seg_bin_display.sv
// Directed bench for seg_bin_display: conversions, blanking, DP, overflow,
// ignored requests and reset mid-conversion.
module tb_seg_bin_display;

  localparam int unsigned BIN_W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] bin_data;
  logic [5:0]       dp_en;
  logic             done;
  logic             overflow;
  logic [7:0]       s0, s1, s2, s3, s4, s5;

  int n_cmp = 0;
  int n_err = 0;

  seg_bin_display #(.BIN_W(BIN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bin_data   (bin_data),
    .dp_en      (dp_en),
    .done       (done),
    .overflow   (overflow),
    .seg_data_0 (s0),
    .seg_data_1 (s1),
    .seg_data_2 (s2),
    .seg_data_3 (s3),
    .seg_data_4 (s4),
    .seg_data_5 (s5)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected patterns given digit 5 first, digit 0 last.
  task automatic check_segs(input string tag, input logic [47:0] exp);
    logic [47:0] got;
    got = {s5, s4, s3, s2, s1, s0};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_d%0d", tag, i), 48'(got[8*i +: 8]), 48'(exp[8*i +: 8]));
    end
  endtask

  // Accept one value, scramble inputs while busy, wait for done and check latency.
  task automatic run_conv(input string tag, input logic [BIN_W-1:0] v, input logic [5:0] d);
    int n;
    bin_data = v;
    dp_en    = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, 48'(in_ready), 48'(0));
    bin_data = '1;
    dp_en    = 6'h3f;
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 48'(n), 48'(BIN_W + 1));
    check({tag, "_rdy"}, 48'(in_ready), 48'(1));
  endtask

  initial begin
    int pulses;
    rst      = 1'b1;
    in_valid = 1'b0;
    bin_data = '0;
    dp_en    = '0;
    step();
    step();
    rst = 1'b0;
    repeat (5) step();
    check_segs("rst", {6{8'hff}});
    check("rst_rdy", 48'(in_ready), 48'(1));
    check("rst_done", 48'(done), 48'(0));
    check("rst_ovf", 48'(overflow), 48'(0));

    run_conv("v123456", 20'd123456, 6'b000000);
    check_segs("v123456", {8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82});
    check("v123456_ovf", 48'(overflow), 48'(0));
    step();
    check("v123456_pulse", 48'(done), 48'(0));
    check_segs("v123456_hold", {8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82});

    run_conv("v0", 20'd0, 6'b000100);
    check_segs("v0", {8'hff, 8'hff, 8'hff, 8'h7f, 8'hff, 8'hc0});

    run_conv("v100500", 20'd100500, 6'b000000);
    check_segs("v100500", {8'hf9, 8'hc0, 8'hc0, 8'h92, 8'hc0, 8'hc0});

    run_conv("ovf", 20'd1000000, 6'b000000);
    check_segs("ovf", {6{8'hbf}});
    check("ovf_flag", 48'(overflow), 48'(1));

    run_conv("ovfdp", 20'hfffff, 6'b000001);
    check_segs("ovfdp", {8'hbf, 8'hbf, 8'hbf, 8'hbf, 8'hbf, 8'h3f});

    run_conv("v999999", 20'd999999, 6'b000000);
    check_segs("v999999", {6{8'h90}});
    check("v999999_ovf", 48'(overflow), 48'(0));

    // Request for 42 during conversion of 7 must be dropped.
    step();
    bin_data = 20'd7;
    dp_en    = '0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    bin_data = 20'd42;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      step();
    end
    check("ign_pulses", 48'(pulses), 48'(1));
    check_segs("ign", {8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hf8});

    // Reset mid-SHIFT, with in_valid held during reset.
    bin_data = 20'd555555;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst      = 1'b1;
    in_valid = 1'b1;
    bin_data = 20'd3;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_segs("mrst", {6{8'hff}});
    check("mrst_rdy", 48'(in_ready), 48'(1));
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) pulses++;
      step();
    end
    check("mrst_pulses", 48'(pulses), 48'(0));
    check_segs("mrst_idle", {6{8'hff}});

    run_conv("v5", 20'd5, 6'b000000);
    check_segs("v5", {8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'h92});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
